angle_frame_packer: RTL
=======================

Name: angle_frame_packer

Overview:
- Sits between bi_microphone and the UART byte transmitter.
- Buffers 16-bit angle results and wraps each one in a 5-byte framed packet: header, sequence, angle high, angle low, checksum.
- Feeds the transmitter one byte at a time over a valid/ready handshake.
- Lets the host resynchronise on the stream, and lets it detect lost results and corrupted results.

Parameters:
- FIFO_DEPTH, 4, number of buffered angle results; power of two, at least 2.
- HDR_BYTE, 8'hA5, constant first byte of every frame.

Ports:
- clk_60MHz  input  1  system clock, all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- angle_valid  input  1  single-cycle strobe; the angle is present this cycle.
- angle  input  16  signed angle result, sampled when angle_valid=1.
- tx_ready  input  1  byte transmitter can accept a byte.
- tx_valid  output  1  tx_data holds a byte to send.
- tx_data  output  8  byte to transmit.
- busy  output  1  high while a frame is in flight or the FIFO is not empty.
- drop_cnt  output  8  count of dropped angle results, saturating.

Behaviour:
- Clock and reset: one clock (clk_60MHz); reset is synchronous and active-high (rst).
- Reset values: tx_valid=0, tx_data=8'h00, busy=0, drop_cnt=0; FIFO empty; seq=0; FSM in IDLE.
- Reset mid-frame aborts the frame with no completion. tx_valid is 0 on the first cycle after rst is sampled high.
- Byte handshake: a byte transfers on any cycle with tx_valid=1 and tx_ready=1.
  - While tx_valid=1 and tx_ready=0, tx_valid and tx_data hold stable.
  - tx_valid never drops without a transfer, except on reset.
- FIFO push: a push occurs when angle_valid=1 and the FIFO is not full.
  - If the FIFO is full and a pop occurs in the same cycle, the push is still accepted; the count is unchanged.
  - If the FIFO is full with no pop, the angle is dropped and drop_cnt increments, saturating at 8'hFF.
  - Read and write pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished with an extra pointer bit.
- FSM states: IDLE, HDR, SEQ, HI, LO, CSUM.
  - IDLE: if the FIFO is not empty, pop the head into the frame register and go to HDR. Present tx_valid=1 with tx_data=HDR_BYTE on the next cycle.
  - HDR, SEQ, HI and LO each advance to the next state on a transfer. The next byte is presented in the cycle after the transfer, so there is one registered byte per state.
  - CSUM: on transfer, seq increments and the FSM returns to IDLE.
  - tx_valid=0 in the IDLE cycle, giving a minimum one-cycle gap between frames.
- Byte contents:
  - HDR = HDR_BYTE.
  - SEQ = current seq.
  - HI = angle[15:8].
  - LO = angle[7:0].
  - CSUM = (seq + angle[15:8] + angle[7:0]) mod 256. This is an 8-bit unsigned sum with the carry discarded; the header is excluded.
- seq is 8 bits and increments once per completed frame, wrapping 8'hFF to 8'h00.
- Latency: an angle_valid at cycle t into an empty FIFO with the FSM in IDLE is popped at t+1. tx_valid=1 with HDR appears at t+2.
  - With tx_ready held high, the frame completes at t+6 and the next pop can occur at t+7.
  - Minimum frame period is 6 cycles.
- The angle is captured at pop time. Later FIFO writes do not alter the frame in flight.
- busy = (FSM != IDLE) OR (FIFO not empty), registered. It equals the state after the current edge.
- angle_valid held high for several cycles pushes one entry per cycle. Angle is not edge-detected.

Test Plan:
- Single frame: after reset, pulse angle_valid with angle=16'h1234, tx_ready=1 throughout.
  - Required: byte sequence A5,00,12,34,46; HDR appears 2 cycles after the strobe; busy falls after CSUM.
- Back-pressure: send angle=16'hFF80 with tx_ready toggling 1,0,0,1,...
  - Required: bytes A5,00,FF,80,7F; tx_data stable while stalled; no duplicated or skipped bytes.
- Overflow: tx_ready=0, then 6 consecutive angle_valid pulses with angles 1..6, then tx_ready=1.
  - Required with FIFO_DEPTH=4 and 1 entry popped into the frame: 5 accepted, 1 dropped, drop_cnt=1.
  - Required: frames carry angles 1..5 with seq 0..4.
- Seq wrap: send 257 frames.
  - Required: the 256th frame has seq=FF, the 257th has seq=00, and its CSUM uses 00.
- Reset mid-frame: assert rst for 1 cycle after the HI byte transfers.
  - Required: tx_valid=0 next cycle, drop_cnt=0, busy=0.
  - Required: the next angle produces a frame with seq=00 starting with A5.
- Full plus simultaneous pop: with the FIFO full and the FSM in IDLE, strobe angle_valid in the pop cycle.
  - Required: the push is accepted and drop_cnt is unchanged.

Source files
------------

// File: rtl/angle_frame_packer.sv
// Buffers 16-bit angle results and streams each as a 5-byte frame
// (header, seq, angle hi, angle lo, checksum) over a byte valid/ready link.
module angle_frame_packer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  HDR_BYTE   = 8'hA5
) (
  input  logic        clk_60MHz,
  input  logic        rst,
  input  logic        angle_valid,
  input  logic [15:0] angle,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic [7:0]  drop_cnt
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_SEQ  = 3'd2;
  localparam logic [2:0] S_HI   = 3'd3;
  localparam logic [2:0] S_LO   = 3'd4;
  localparam logic [2:0] S_CSUM = 3'd5;

  logic [15:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic          fifo_empty, fifo_full, push, pop;

  logic [2:0]    state, state_nxt;
  logic [15:0]   frame_angle;
  logic [7:0]    seq, seq_nxt;
  logic [7:0]    csum;
  logic          tx_valid_nxt;
  logic [7:0]    tx_data_nxt;
  logic          xfer;

  // Extra pointer MSB separates full from empty when the index bits match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign pop  = (state == S_IDLE) && !fifo_empty;
  assign push = angle_valid && (!fifo_full || pop);

  assign wr_ptr_nxt = push ? wr_ptr + PW'(1) : wr_ptr;
  assign rd_ptr_nxt = pop  ? rd_ptr + PW'(1) : rd_ptr;

  assign xfer = tx_valid && tx_ready;
  assign csum = 8'(seq + frame_angle[15:8] + frame_angle[7:0]);

  // Storage has no reset; validity is tracked by the pointers.
  always_ff @(posedge clk_60MHz) begin
    if (push) mem[wr_ptr[AW-1:0]] <= angle;
  end

  always_ff @(posedge clk_60MHz) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      drop_cnt <= 8'h00;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      if (angle_valid && fifo_full && !pop && (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Angle is latched at pop so later pushes cannot disturb the frame in flight.
  always_ff @(posedge clk_60MHz) begin
    if (rst)      frame_angle <= 16'h0000;
    else if (pop) frame_angle <= mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk_60MHz) begin
    if (rst) begin
      state    <= S_IDLE;
      seq      <= 8'h00;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      seq      <= seq_nxt;
      tx_valid <= tx_valid_nxt;
      tx_data  <= tx_data_nxt;
      busy     <= (state_nxt != S_IDLE) || (wr_ptr_nxt != rd_ptr_nxt);
    end
  end

  // Each state owns one registered byte; the next byte is loaded on transfer.
  always_comb begin
    state_nxt    = state;
    seq_nxt      = seq;
    tx_valid_nxt = tx_valid;
    tx_data_nxt  = tx_data;
    case (state)
      S_IDLE: begin
        tx_valid_nxt = 1'b0;
        if (!fifo_empty) begin
          state_nxt    = S_HDR;
          tx_valid_nxt = 1'b1;
          tx_data_nxt  = HDR_BYTE;
        end
      end
      S_HDR: if (xfer) begin
        state_nxt   = S_SEQ;
        tx_data_nxt = seq;
      end
      S_SEQ: if (xfer) begin
        state_nxt   = S_HI;
        tx_data_nxt = frame_angle[15:8];
      end
      S_HI: if (xfer) begin
        state_nxt   = S_LO;
        tx_data_nxt = frame_angle[7:0];
      end
      S_LO: if (xfer) begin
        state_nxt   = S_CSUM;
        tx_data_nxt = csum;
      end
      S_CSUM: if (xfer) begin
        state_nxt    = S_IDLE;
        seq_nxt      = seq + 8'd1;
        tx_valid_nxt = 1'b0;
        tx_data_nxt  = 8'h00;
      end
      default: begin
        state_nxt    = S_IDLE;
        tx_valid_nxt = 1'b0;
        tx_data_nxt  = 8'h00;
      end
    endcase
  end

endmodule
